// File: rtl/arbitro_volume.sv
// arbitro_volume: arbitrates volume commands from the front panel (A) and the
// automation path (B) onto the press-style aumenta/diminui/mute interface of the
// volume FSM. Each granted command becomes a HOLD_CYC-cycle press. The block then
// waits up to TIMEOUT cycles for mudou_volume and pulses ack to the granted requester.
// Ports: clk, reset (async, active high); req_a/cmd_a, req_b/cmd_b (00 aumenta,
//   01 diminui, 10 mute, 11 reserved); mudou_volume; aumenta/diminui/mute (registered
//   press lines); ack_a/ack_b (one-cycle completion); efeito (1 = change seen);
//   ocupado (not idle).
// Optional feature: define ARBITRO_PRIORIDADE_PAINEL_EN for fixed panel priority on
//   ties; the default build uses round-robin between A and B.
module arbitro_volume #(
  parameter int HOLD_CYC = 2,
  parameter int TIMEOUT  = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [1:0] cmd_a,
  input  logic       req_b,
  input  logic [1:0] cmd_b,
  input  logic       mudou_volume,
  output logic       aumenta,
  output logic       diminui,
  output logic       mute,
  output logic       ack_a,
  output logic       ack_b,
  output logic       efeito,
  output logic       ocupado
);

  typedef enum logic [1:0] {OCIOSO, PRESSIONA, ESPERA, CONCLUI} estado_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  estado_t          estado, estado_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  // {mute, diminui, aumenta}; kept one-hot or zero by construction
  logic [2:0]       linhas, linhas_n;
  logic             ack_a_n, ack_b_n, efeito_n;
  logic             dono_b, dono_b_n;      // owner of the command in flight
  logic             ultimo_b, ultimo_b_n;  // last_grant: 1 = B
  logic             escolhe_b;
  logic [1:0]       cmd_sel;

`ifdef ARBITRO_PRIORIDADE_PAINEL_EN
  // Panel always wins a tie; last_grant is still tracked but not consulted.
  assign escolhe_b = req_b & ~req_a;
`else
  // Tie goes to whoever was not granted last.
  assign escolhe_b = req_b & (~req_a | ~ultimo_b);
`endif

  assign cmd_sel = escolhe_b ? cmd_b : cmd_a;

  always_comb begin
    estado_n   = estado;
    cnt_n      = cnt;
    linhas_n   = linhas;
    ack_a_n    = 1'b0;
    ack_b_n    = 1'b0;
    efeito_n   = efeito;
    dono_b_n   = dono_b;
    ultimo_b_n = ultimo_b;
    unique case (estado)
      OCIOSO: begin
        if (req_a | req_b) begin
          dono_b_n   = escolhe_b;
          ultimo_b_n = escolhe_b;
          efeito_n   = 1'b0;
          cnt_n      = '0;
          estado_n   = PRESSIONA;
          unique case (cmd_sel)
            2'b00: linhas_n = 3'b001;
            2'b01: linhas_n = 3'b010;
            2'b10: linhas_n = 3'b100;
            default: begin
              // Reserved command: nothing to press, complete at once with no effect.
              linhas_n = 3'b000;
              estado_n = CONCLUI;
              ack_a_n  = ~escolhe_b;
              ack_b_n  = escolhe_b;
            end
          endcase
        end
      end
      PRESSIONA: begin
        if (cnt == HOLD_LAST) begin
          linhas_n = 3'b000;
          cnt_n    = '0;
          estado_n = ESPERA;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ESPERA: begin
        // A change seen on the last timeout cycle still counts as an effect.
        if (mudou_volume) begin
          estado_n = CONCLUI;
          efeito_n = 1'b1;
          ack_a_n  = ~dono_b;
          ack_b_n  = dono_b;
        end else if (cnt == TO_LAST) begin
          estado_n = CONCLUI;
          efeito_n = 1'b0;
          ack_a_n  = ~dono_b;
          ack_b_n  = dono_b;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      CONCLUI: begin
        // Wait for a late mudou_volume to clear so it is not credited to the next command.
        if (!mudou_volume) estado_n = OCIOSO;
      end
      default: estado_n = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= OCIOSO;
      cnt      <= '0;
      linhas   <= 3'b000;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      efeito   <= 1'b0;
      ocupado  <= 1'b0;
      dono_b   <= 1'b0;
      ultimo_b <= 1'b1;
    end else begin
      estado   <= estado_n;
      cnt      <= cnt_n;
      linhas   <= linhas_n;
      ack_a    <= ack_a_n;
      ack_b    <= ack_b_n;
      efeito   <= efeito_n;
      ocupado  <= (estado_n != OCIOSO);
      dono_b   <= dono_b_n;
      ultimo_b <= ultimo_b_n;
    end
  end

  assign aumenta = linhas[0];
  assign diminui = linhas[1];
  assign mute    = linhas[2];

endmodule

// File: tb/tb_arbitro_volume.sv
// tb_arbitro_volume: directed bench for arbitro_volume with default parameters
// (HOLD_CYC 2, TIMEOUT 8). A small volume-FSM model pulses mudou_volume a set number
// of cycles after a press is released (or never). Cycle k of a run is the k-th cycle after the grant edge.
module tb_arbitro_volume;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, mudou_volume = 1'b0;
  logic [1:0] cmd_a = 2'b00, cmd_b = 2'b00;
  logic       aumenta, diminui, mute, ack_a, ack_b, efeito, ocupado;

  int vectors = 0;
  int miscompares = 0;

  // volume FSM model
  int   mud_dly = -1;
  int   since_rel = -1;
  logic prev_line = 1'b0;
  bit   keep = 1'b0;

  // per-run statistics
  int n_aum, n_dim, n_mute, n_ack, n_ack_a, n_ack_b, first_ack_k, first_line, n_ocup;
  int eff_ack;
  int ack_seq [8];
  int multi_total = 0;

  arbitro_volume dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .cmd_a(cmd_a), .req_b(req_b), .cmd_b(cmd_b),
    .mudou_volume(mudou_volume),
    .aumenta(aumenta), .diminui(diminui), .mute(mute),
    .ack_a(ack_a), .ack_b(ack_b), .efeito(efeito), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic any_line;
    @(posedge clk);
    #1;
    any_line = aumenta | diminui | mute;
    if (prev_line && !any_line) since_rel = 0;
    else if (since_rel >= 0) since_rel++;
    prev_line = any_line;
    mudou_volume = (mud_dly >= 0) && (since_rel == mud_dly);
  endtask

  task automatic run(input int n);
    n_aum = 0; n_dim = 0; n_mute = 0; n_ack = 0; n_ack_a = 0; n_ack_b = 0;
    first_ack_k = 0; first_line = 0; n_ocup = 0; eff_ack = -1;
    for (int i = 0; i < 8; i++) ack_seq[i] = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (int'(aumenta) + int'(diminui) + int'(mute) > 1) multi_total++;
      if (aumenta) n_aum++;
      if (diminui) n_dim++;
      if (mute) n_mute++;
      if (ocupado) n_ocup++;
      if (first_line == 0) begin
        if (aumenta) first_line = 1;
        else if (diminui) first_line = 2;
        else if (mute) first_line = 3;
      end
      if (ack_a || ack_b) begin
        if (n_ack < 8) ack_seq[n_ack] = ack_a ? 1 : 2;
        n_ack++;
        if (first_ack_k == 0) first_ack_k = k;
        eff_ack = int'(efeito);
        if (ack_a) n_ack_a++;
        if (ack_b) n_ack_b++;
        if (!keep) begin
          if (ack_a) req_a = 1'b0;
          if (ack_b) req_b = 1'b0;
        end
      end
    end
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_lines", {29'd0, mute, diminui, aumenta}, 0);
    chk("rst_acks", {30'd0, ack_b, ack_a}, 0);
    chk("rst_efeito", int'(efeito), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    step(); step();
    reset = 1'b0;

    // tie from reset: A (diminui) first, then B (aumenta)
    req_a = 1'b1; cmd_a = 2'b01; req_b = 1'b1; cmd_b = 2'b00; mud_dly = 0;
    run(12);
    chk("tie1_first", ack_seq[0], 1);
    chk("tie1_second", ack_seq[1], 2);
    chk("tie1_nack", n_ack, 2);
    chk("tie1_line", first_line, 2);
    chk("tie1_ackk", first_ack_k, 4);
    chk("tie1_dim", n_dim, 2);
    chk("tie1_aum", n_aum, 2);

    // next tie goes to A again
    req_a = 1'b1; cmd_a = 2'b10; req_b = 1'b1; cmd_b = 2'b01;
    run(12);
    chk("tie2_first", ack_seq[0], 1);
    chk("tie2_second", ack_seq[1], 2);
    chk("tie2_line", first_line, 3);
    chk("tie2_mute", n_mute, 2);

    // single A aumenta, change 3 cycles after release
    req_a = 1'b1; cmd_a = 2'b00; mud_dly = 3;
    run(12);
    chk("a_aum_cyc", n_aum, 2);
    chk("a_ack_a", n_ack_a, 1);
    chk("a_ack_b", n_ack_b, 0);
    chk("a_ackk", first_ack_k, 7);
    chk("a_eff", eff_ack, 1);
    chk("a_eff_held", int'(efeito), 1);
    chk("a_idle", int'(ocupado), 0);

    // B timeout, volume at limit
    req_b = 1'b1; cmd_b = 2'b00; mud_dly = -1;
    run(14);
    chk("to_ackk", first_ack_k, 11);
    chk("to_ack_b", n_ack_b, 1);
    chk("to_ack_a", n_ack_a, 0);
    chk("to_eff", eff_ack, 0);
    chk("to_aum", n_aum, 2);
    chk("to_ocup", n_ocup, 11);

    // change arrives after timeout: stay in CONCLUI, single ack
    req_a = 1'b1; cmd_a = 2'b00; mud_dly = 8;
    run(16);
    chk("late_ackk", first_ack_k, 11);
    chk("late_nack", n_ack, 1);
    chk("late_eff", eff_ack, 0);
    chk("late_ocup", n_ocup, 12);

    // change on the final timeout cycle wins
    req_b = 1'b1; cmd_b = 2'b01; mud_dly = 7;
    run(14);
    chk("edge_ackk", first_ack_k, 11);
    chk("edge_eff", eff_ack, 1);
    chk("edge_dim", n_dim, 2);

    // reserved command
    req_a = 1'b1; cmd_a = 2'b11; mud_dly = -1;
    run(5);
    chk("rsv_ackk", first_ack_k, 1);
    chk("rsv_lines", n_aum + n_dim + n_mute, 0);
    chk("rsv_eff", eff_ack, 0);
    chk("rsv_ack_a", n_ack_a, 1);
    chk("rsv_ocup", n_ocup, 1);

    // reset during PRESSIONA
    req_a = 1'b1; cmd_a = 2'b10; req_b = 1'b1; cmd_b = 2'b01;
    step();
`ifdef ARBITRO_PRIORIDADE_PAINEL_EN
    chk("abort_press", {29'd0, mute, diminui, aumenta}, 4);
`else
    chk("abort_press", {29'd0, mute, diminui, aumenta}, 2);
`endif
    reset = 1'b1;
    #1;
    chk("abort_lines", {29'd0, mute, diminui, aumenta}, 0);
    chk("abort_ocup", int'(ocupado), 0);
    req_a = 1'b0; req_b = 1'b0;
    step();
    chk("abort_noack1", {30'd0, ack_b, ack_a}, 0);
    step();
    chk("abort_noack2", {30'd0, ack_b, ack_a}, 0);
    reset = 1'b0;
    req_a = 1'b1; cmd_a = 2'b00; req_b = 1'b1; cmd_b = 2'b01; mud_dly = 0;
    run(12);
    chk("post_rst_first", ack_seq[0], 1);
    chk("post_rst_line", first_line, 1);
    chk("post_rst_nack_a", n_ack_a, 1);
    chk("post_rst_nack_b", n_ack_b, 1);

    // both requesting continuously for five commands
    keep = 1'b1;
    req_a = 1'b1; cmd_a = 2'b00; req_b = 1'b1; cmd_b = 2'b01;
    run(25);
    req_a = 1'b0; req_b = 1'b0; keep = 1'b0;
    chk("cont_nack", n_ack, 5);
`ifdef ARBITRO_PRIORIDADE_PAINEL_EN
    chk("cont_ack_a", n_ack_a, 5);
    chk("cont_ack_b", n_ack_b, 0);
`else
    chk("cont_ack_a", n_ack_a, 3);
    chk("cont_ack_b", n_ack_b, 2);
    chk("cont_second", ack_seq[1], 2);
`endif
    run(4);
    chk("drain_idle", int'(ocupado), 0);
    chk("drain_nack", n_ack, 0);
    chk("onehot", multi_total, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/arbitro_volume.md
Name: arbitro_volume

Overview:
- Arbitrates volume commands from two requesters onto the single button-style command interface of the volume state machine.
- Requester A is the front-panel debouncer; requester B is the automation/sequencer path.
- Converts each granted command into a press/release pulse on aumenta, diminui or mute, then waits for mudou_volume or a timeout before acknowledging.
- Sits between the input-conditioning logic and the volume FSM.

Parameters:
- HOLD_CYC, 2, cycles the selected command line is held high (press width); legal range 1 to 2^CNT_W-1.
- TIMEOUT, 8, cycles to wait for mudou_volume after release before declaring "no effect"; legal range 1 to 2^CNT_W-1.
- CNT_W, 4, width of the shared cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A (panel) command valid.
- cmd_a  in  2  requester A command: 00 aumenta, 01 diminui, 10 mute, 11 reserved.
- req_b  in  1  requester B (automation) command valid.
- cmd_b  in  2  requester B command, same encoding as cmd_a.
- mudou_volume  in  1  change indication from the volume FSM.
- aumenta  out  1  registered press line to the volume FSM.
- diminui  out  1  registered press line to the volume FSM.
- mute  out  1  registered press line to the volume FSM.
- ack_a  out  1  one-cycle completion pulse to requester A.
- ack_b  out  1  one-cycle completion pulse to requester B.
- efeito  out  1  valid with ack_*: 1 = mudou_volume seen, 0 = timeout or reserved command.
- ocupado  out  1  high in every state except OCIOSO.

Behaviour:
- Reset (async, any state): state OCIOSO; aumenta, diminui, mute, ack_a, ack_b, efeito, ocupado all 0; counter 0; last_grant = B, so A wins the first tie.
- All outputs are registered. At most one of aumenta, diminui, mute is high at any time.
- States:
  - OCIOSO → PRESSIONA: with any req high, grant, latch cmd, set the matching line and counter 0.
  - Grant policy (no macro): single request wins; on a tie, the requester not equal to last_grant wins (round-robin). last_grant updates on grant.
  - Reserved cmd 11: no line driven; go directly to CONCLUI with efeito = 0.
  - PRESSIONA: line stays high. When counter == HOLD_CYC-1, drop the line, clear the counter and go to ESPERA. Otherwise increment the counter.
  - ESPERA: all lines low. If mudou_volume = 1, go to CONCLUI with efeito = 1. Else if counter == TIMEOUT-1, go to CONCLUI with efeito = 0. Otherwise increment the counter. mudou_volume has priority over timeout when both occur in the same cycle.
  - CONCLUI: pulse ack to the granted requester for exactly one cycle (in the cycle CONCLUI is entered); efeito is held until the next grant. Go to OCIOSO only once mudou_volume = 0; stay in CONCLUI while it is high, with no further ack.
- Latency from grant, cmd 00/01/10 with immediate mudou_volume: line high for HOLD_CYC cycles, then ack ≥ 1 cycle after release.
- Latency for timeout: ack HOLD_CYC + TIMEOUT + 1 cycles after the grant edge.
- Requester contract: hold req/cmd stable until ack. A req dropped mid-command does not abort it; ack is still issued. A req still high in the cycle after its ack is a new request.
- A volume at its limit produces no mudou_volume; this is reported as efeito = 0, not as an error.
- Reset mid-press drops the line asynchronously; no ack is issued for the aborted command.

Optional Feature:
- Macro: ARBITRO_PRIORIDADE_PAINEL_EN.
- Defined: fixed priority; requester A always wins a tie and last_grant is ignored. B can starve while A keeps requesting.
- Undefined: round-robin as above.

Test Plan:
- Single A cmd 00, FSM model pulses mudou_volume 3 cycles after release → aumenta high exactly 2 cycles, ack_a single pulse, efeito = 1, ack_b never high.
- A and B both request from reset (cmd_a 01, cmd_b 00) → A served first (diminui), then B (aumenta); next tie goes to A again; exactly one ack per command.
- B cmd 00 with mudou_volume held 0 (volume at 10) → ack_b 11 cycles after grant (2+8+1), efeito = 0.
- cmd_a 11 → no line ever asserted, ack_a one cycle after grant, efeito = 0.
- Assert reset during PRESSIONA → lines low in the same cycle, ocupado = 0, no ack; next tie grants A.
- With ARBITRO_PRIORIDADE_PAINEL_EN defined, A and B requesting continuously → only ack_a pulses for 5 consecutive commands.
